// File: rtl/spad_read_controller_ifmap.sv
// rtl/spad_read_controller_ifmap.sv - circular IFMap scratchpad window reader
// Optional feature macro: SPAD_RD_WIN_CNT_EN (adds the win_cnt window counter output).
module spad_read_controller_ifmap #(
    parameter int SPAD_ADDR_WIDTH = 3,
    parameter int SPAD_DEPTH      = 7,
    parameter int FILT_WIDTH      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init,
    input  logic                       stall,
    input  logic [FILT_WIDTH-1:0]      filt_len,
    input  logic [FILT_WIDTH-1:0]      stride,
    input  logic                       valid_start,
    input  logic                       valid_end,
    input  logic [SPAD_ADDR_WIDTH-1:0] start_data,
    input  logic [SPAD_ADDR_WIDTH-1:0] end_data,
    input  logic [SPAD_ADDR_WIDTH-1:0] spad_waddr,
    input  logic                       out_ready,
    output logic                       ren_spad,
    output logic [SPAD_ADDR_WIDTH-1:0] spad_raddr,
    output logic                       win_last,
    output logic                       done
`ifdef SPAD_RD_WIN_CNT_EN
    ,
    output logic [FILT_WIDTH+SPAD_ADDR_WIDTH-1:0] win_cnt
`endif
);

    localparam int M  = SPAD_DEPTH + 1;
    localparam int AW = SPAD_ADDR_WIDTH;
    localparam int DW = SPAD_ADDR_WIDTH + 1;
    localparam int SW = SPAD_ADDR_WIDTH + FILT_WIDTH + 1;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_START = 3'd1;
    localparam logic [2:0] ST_READ       = 3'd2;
    localparam logic [2:0] ST_NEXT       = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    // Ring distance from a forward to b, one bit wider than an address.
    function automatic logic [DW-1:0] ring_dist(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [DW-1:0] t;
        t = {1'b0, b} + DW'(M) - {1'b0, a};
        if (t >= DW'(M)) begin
            t = t - DW'(M);
        end
        return t;
    endfunction

    function automatic logic [AW-1:0] ring_add(input logic [AW-1:0] a, input logic [FILT_WIDTH-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        s = s % SW'(M);
        return s[AW-1:0];
    endfunction

    logic [2:0]            state_q, state_d;
    logic [AW-1:0]         base_q, base_d;
    logic [FILT_WIDTH-1:0] k_q, k_d;
    logic [FILT_WIDTH-1:0] fl_q, fl_d;
    logic [FILT_WIDTH-1:0] st_q, st_d;
`ifdef SPAD_RD_WIN_CNT_EN
    logic [FILT_WIDTH+AW-1:0] win_cnt_q, win_cnt_d;
    assign win_cnt = win_cnt_q;
`endif

    logic [AW-1:0] addr;
    logic [DW-1:0] d_addr, d_end, d_wr, d_base;
    logic          avail, fit, last_k;

    assign addr   = ring_add(base_q, k_q);
    assign d_addr = ring_dist(start_data, addr);
    assign d_end  = ring_dist(start_data, end_data);
    assign d_wr   = ring_dist(start_data, spad_waddr);
    assign d_base = ring_dist(start_data, base_q);

    // While the row end is unknown, only entries already written are readable.
    assign avail  = valid_end ? (d_addr <= d_end) : (d_addr < d_wr);
    assign fit    = (SW'(d_base) + SW'(fl_q)) <= (SW'(d_end) + SW'(1));
    assign last_k = (k_q == (fl_q - FILT_WIDTH'(1)));

    assign spad_raddr = addr;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        k_d      = k_q;
        fl_d     = fl_q;
        st_d     = st_q;
        ren_spad = 1'b0;
        win_last = 1'b0;
        done     = 1'b0;
`ifdef SPAD_RD_WIN_CNT_EN
        win_cnt_d = win_cnt_q;
`endif
        if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (init) begin
                        fl_d    = (filt_len == '0) ? FILT_WIDTH'(1) : filt_len;
                        st_d    = (stride == '0) ? FILT_WIDTH'(1) : stride;
                        state_d = ST_WAIT_START;
                    end
                end
                ST_WAIT_START: begin
                    if (valid_start) begin
                        base_d  = start_data;
                        k_d     = '0;
                        state_d = ST_READ;
                    end
                end
                ST_READ: begin
                    if ((k_q == '0) && valid_end && !fit) begin
                        state_d = ST_DONE;
                    end else if (avail && out_ready) begin
                        ren_spad = 1'b1;
                        if (last_k) begin
                            win_last = 1'b1;
                            state_d  = ST_NEXT;
                        end else begin
                            k_d = k_q + FILT_WIDTH'(1);
                        end
                    end
                end
                ST_NEXT: begin
                    base_d  = ring_add(base_q, st_q);
                    k_d     = '0;
                    state_d = ST_READ;
`ifdef SPAD_RD_WIN_CNT_EN
                    if (win_cnt_q != '1) begin
                        win_cnt_d = win_cnt_q + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_WAIT_START;
`ifdef SPAD_RD_WIN_CNT_EN
                    win_cnt_d = '0;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            k_q     <= '0;
            fl_q    <= '0;
            st_q    <= '0;
`ifdef SPAD_RD_WIN_CNT_EN
            win_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            fl_q    <= fl_d;
            st_q    <= st_d;
`ifdef SPAD_RD_WIN_CNT_EN
            win_cnt_q <= win_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_spad_read_controller_ifmap.sv
// tb/tb_spad_read_controller_ifmap.sv - directed self-checking bench for spad_read_controller_ifmap
module tb_spad_read_controller_ifmap;

    localparam int AW = 3;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init = 1'b0;
    logic          stall = 1'b0;
    logic [FW-1:0] filt_len = '0;
    logic [FW-1:0] stride = '0;
    logic          valid_start = 1'b0;
    logic          valid_end = 1'b0;
    logic [AW-1:0] start_data = '0;
    logic [AW-1:0] end_data = '0;
    logic [AW-1:0] spad_waddr = '0;
    logic          out_ready = 1'b1;
    logic          ren_spad;
    logic [AW-1:0] spad_raddr;
    logic          win_last;
    logic          done;
`ifdef SPAD_RD_WIN_CNT_EN
    logic [FW+AW-1:0] win_cnt;
`endif

    always #5 clk = ~clk;

    spad_read_controller_ifmap #(
        .SPAD_ADDR_WIDTH(AW),
        .SPAD_DEPTH(7),
        .FILT_WIDTH(FW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .init(init),
        .stall(stall),
        .filt_len(filt_len),
        .stride(stride),
        .valid_start(valid_start),
        .valid_end(valid_end),
        .start_data(start_data),
        .end_data(end_data),
        .spad_waddr(spad_waddr),
        .out_ready(out_ready),
        .ren_spad(ren_spad),
        .spad_raddr(spad_raddr),
        .win_last(win_last),
        .done(done)
`ifdef SPAD_RD_WIN_CNT_EN
        ,
        .win_cnt(win_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xa[$];
    int xl[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int last_xfer_cyc = 0;

    int basic_a[$] = '{0, 1, 2, 1, 2, 3, 2, 3, 4, 3, 4, 5};
    int basic_l[$] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int wrap_a[$]  = '{6, 7, 0, 1};
    int wrap_l[$]  = '{0, 1, 0, 1};
    int thr_a[$]   = '{0, 1, 2, 1, 2};
    int thr_l[$]   = '{0, 0, 1, 0, 0};

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (ren_spad && out_ready) begin
                xa.push_back(int'(spad_raddr));
                xl.push_back(int'(win_last));
                last_xfer_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_run(input int fl, input int st, input int sd, input int ed, input int ve);
        rst = 1'b1;
        init = 1'b0;
        stall = 1'b0;
        valid_start = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        filt_len = FW'(fl);
        stride = FW'(st);
        start_data = AW'(sd);
        end_data = AW'(ed);
        valid_end = ve[0];
        spad_waddr = '0;
        valid_start = 1'b1;
        init = 1'b1;
        xa.delete();
        xl.delete();
        done_cnt = 0;
        @(posedge clk);
        #1;
        init = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < maxc);
        check_eq({tag, "_done_seen"}, int'(done), 1);
        valid_start = 1'b0;
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, int'(done), 0);
    endtask

    task automatic check_seq(input string tag, input int ea[$], input int el[$]);
        check_eq({tag, "_len"}, xa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < xa.size(); i++) begin
            check_eq($sformatf("%s_addr%0d", tag, i), xa[i], ea[i]);
            check_eq($sformatf("%s_last%0d", tag, i), xl[i], el[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ren", int'(ren_spad), 0);
        check_eq("rst_last", int'(win_last), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_raddr", int'(spad_raddr), 0);

        start_run(3, 1, 0, 5, 1);
        wait_done("basic", 100);
        check_seq("basic", basic_a, basic_l);
        check_eq("basic_done_lat", done_cyc - last_xfer_cyc, 3);
        check_eq("basic_done_cnt", done_cnt, 1);
`ifdef SPAD_RD_WIN_CNT_EN
        check_eq("basic_win_cnt", int'(win_cnt), 0);
`endif

        start_run(2, 2, 6, 2, 1);
        wait_done("wrap", 60);
        check_seq("wrap", wrap_a, wrap_l);

        start_run(3, 1, 0, 0, 0);
        spad_waddr = 3'd0;
        @(negedge clk);
        check_eq("thr_ren_w0", int'(ren_spad), 0);
        @(posedge clk);
        #1;
        for (int w = 1; w < 3; w++) begin
            spad_waddr = AW'(w);
            repeat (2) @(posedge clk);
            #1;
        end
        check_eq("thr_before_w3", xa.size(), 2);
        check_eq("thr_ren_wait", int'(ren_spad), 0);
        spad_waddr = 3'd3;
        repeat (4) @(posedge clk);
        #1;
        check_seq("thr", thr_a, thr_l);
        check_eq("thr_ren_hold", int'(ren_spad), 0);
        check_eq("thr_no_done", done_cnt, 0);

        start_run(3, 1, 0, 5, 1);
        n = 0;
        while (xa.size() < 4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("bp_reach", xa.size(), 4);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq($sformatf("bp_ren%0d", i), int'(ren_spad), 0);
            check_eq($sformatf("bp_raddr%0d", i), int'(spad_raddr), 2);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("stall_ren%0d", i), int'(ren_spad), 0);
            check_eq($sformatf("stall_raddr%0d", i), int'(spad_raddr), 2);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        wait_done("bp", 100);
        check_seq("bp", basic_a, basic_l);

        start_run(4, 1, 3, 4, 1);
        wait_done("short", 20);
        check_eq("short_reads", xa.size(), 0);
`ifdef SPAD_RD_WIN_CNT_EN
        check_eq("short_win_cnt", int'(win_cnt), 0);
`endif
        end_data = 3'd7;
        valid_start = 1'b1;
        n = 0;
        while (xa.size() < 4 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("short_restart_len", xa.size(), 4);
        if (xa.size() >= 4) begin
            check_eq("short_restart_addr0", xa[0], 3);
            check_eq("short_restart_last3", xl[3], 1);
        end

        start_run(3, 1, 0, 5, 1);
        n = 0;
        while (xa.size() < 1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("rmw_reach", xa.size(), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rmw_ren", int'(ren_spad), 0);
        check_eq("rmw_last", int'(win_last), 0);
        check_eq("rmw_done", int'(done), 0);
        check_eq("rmw_raddr", int'(spad_raddr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rmw_no_done", done_cnt, 0);
        check_eq("rmw_idle_ren", int'(ren_spad), 0);
        xa.delete();
        xl.delete();
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        wait_done("rmw_restart", 100);
        check_seq("rmw_restart", basic_a, basic_l);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spad_read_controller_ifmap.md
Name: spad_read_controller_ifmap

Overview:
- Sits directly downstream of the IFMap buffer-read controller.
- Consumes that block's row bookkeeping (start_data, end_data, valid_start, valid_end, spad_waddr) and walks the IFMap scratchpad as a circular buffer.
- Issues filt_len consecutive reads per convolution window, then slides the window by stride.
- Pulses done when no further window fits in the current row; the upstream block uses done to retire the row and reuse its entries.

Parameters:
SPAD_ADDR_WIDTH, 3, scratchpad address width
SPAD_DEPTH, 7, highest scratchpad address; addresses wrap SPAD_DEPTH -> 0 (SPAD_DEPTH+1 entries)
FILT_WIDTH, 3, width of filt_len and stride ports

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
init  input  1  start pulse; samples filt_len and stride
stall  input  1  global freeze
filt_len  input  FILT_WIDTH  window length; 0 treated as 1
stride  input  FILT_WIDTH  window step; 0 treated as 1
valid_start  input  1  start_data holds a valid row start
valid_end  input  1  end_data holds a valid row end
start_data  input  SPAD_ADDR_WIDTH  first address of current row
end_data  input  SPAD_ADDR_WIDTH  last address of current row
spad_waddr  input  SPAD_ADDR_WIDTH  upstream write pointer (next address to be written)
out_ready  input  1  PE accepts a read this cycle
ren_spad  output  1  scratchpad read enable / element valid to PE
spad_raddr  output  SPAD_ADDR_WIDTH  scratchpad read address
win_last  output  1  qualifies ren_spad: last element of window
done  output  1  one-cycle pulse: row finished

Behaviour:
- Reset: state IDLE; ren_spad=0, win_last=0, done=0, spad_raddr=0. Internal base, k, filt_len/stride copies cleared.
- Reset mid-operation aborts the row and does not emit done.
- All arithmetic is modulo M = SPAD_DEPTH+1.
  - dist(a,b) = (b-a) mod M, computed one bit wider than SPAD_ADDR_WIDTH.
  - addr = (base+k) mod M.
- Availability of addr:
  - valid_end=1: dist(start_data, addr) <= dist(start_data, end_data).
  - valid_end=0: dist(start_data, addr) < dist(start_data, spad_waddr); when spad_waddr==start_data, nothing is available.
- Window fit (valid_end=1 only): dist(start_data, base) + FL - 1 <= dist(start_data, end_data), where FL is the latched filt_len.
- States:
  - IDLE: on init, latch FL and ST (0 -> 1), go WAIT_START.
  - WAIT_START: on valid_start, base <= start_data, k <= 0, go READ.
  - READ, k==0 and valid_end and window does not fit: go DONE, no read.
  - READ, otherwise, when addr is available and out_ready:
    - ren_spad=1, spad_raddr=addr.
    - If k==FL-1: win_last=1, go NEXT; else k <= k+1.
  - READ, addr unavailable or out_ready=0: ren_spad=0, hold state.
  - NEXT: base <= (base+ST) mod M, k <= 0, go READ. The fit check runs in READ on the next cycle.
  - DONE: done=1 for exactly one cycle, go WAIT_START. The upstream block's new start_data is sampled from the following cycle onward.
- ren_spad, spad_raddr and win_last are combinational from state, k and base.
  - Zero-latency handshake: an element transfers in a cycle with ren_spad && out_ready.
  - Scratchpad data returns one cycle later; this is the PE's concern.
- stall=1 freezes every register and forces ren_spad=0, win_last=0, done=0. Stall has priority over init and all other inputs.
- init while not IDLE is ignored; FL and ST are fixed for the whole run.
- A row shorter than FL with valid_end=1 produces done with zero reads.
- base advancing past end_data in a full-depth ring: the fit check uses dist from start_data, so a wrapped base produces a large dist and the row terminates; there is no false fit.

Optional Feature:
- Macro SPAD_RD_WIN_CNT_EN.
- Defined:
  - Extra output win_cnt, width FILT_WIDTH+SPAD_ADDR_WIDTH.
  - Increments in NEXT (not during stall) and clears on the done cycle and on reset.
  - Saturates at all-ones.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- Basic row: FL=3, ST=1, start=0, end=5 with valid_end=1 from the first cycle, out_ready=1 -> read sequence 0,1,2 | 1,2,3 | 2,3,4 | 3,4,5. win_last on addresses 2,3,4,5. done one cycle after the last window fails the fit check.
- Wrap: start=6, end=2 (M=8), FL=2, ST=2 -> reads 6,7 | 0,1, then done. No address outside {6,7,0,1,2}.
- Write-pointer throttle: valid_end=0, start=0, spad_waddr advancing 0->3 one step per 2 cycles, FL=3 -> address 2 not issued until spad_waddr=3; ren_spad low while waiting.
- Back-pressure and stall: drop out_ready for 2 cycles mid-window, then stall for 3 cycles -> spad_raddr and k held, no ren_spad. Sequence resumes identically; no element duplicated or skipped.
- Short row: FL=4, start=3, end=4, valid_end=1 -> zero reads, done pulse, return to WAIT_START. With the macro defined, win_cnt=0.
- Reset mid-window: assert rst during the k=1 read -> next cycle IDLE, all outputs 0, no done. A new init restarts cleanly.
